// File: rtl/laser_dwell_sequencer.sv
// Per-pixel galvo/laser sequencer: accept, settle, dwell each colour for its cost, blank.
// Optional LASER_DWELL_STATS_EN adds completed-pixel and laser-on cycle counters.
module laser_dwell_sequencer #(
  parameter int COST_W        = 9,
  parameter int POS_W         = 10,
  parameter int SETTLE_CYCLES = 16,
  parameter int BLANK_CYCLES  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [POS_W-1:0]  pix_x,
  input  logic [POS_W-1:0]  pix_y,
  input  logic [COST_W-1:0] pixel_red_cost,
  input  logic [COST_W-1:0] pixel_green_cost,
  input  logic [COST_W-1:0] pixel_blue_cost,
  output logic [POS_W-1:0]  galvo_x,
  output logic [POS_W-1:0]  galvo_y,
  output logic              laser_red,
  output logic              laser_green,
  output logic              laser_blue,
  output logic              busy,
  output logic              pixel_done
`ifdef LASER_DWELL_STATS_EN
  ,
  output logic [31:0]       stat_pixels,
  output logic [31:0]       stat_on_cycles
`endif
);

  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int BLK_W  = $clog2(BLANK_CYCLES + 1);
  localparam int CNT_W0 = (COST_W + 1 > SET_W) ? COST_W + 1 : SET_W;
  localparam int CNT_W  = (CNT_W0 > BLK_W) ? CNT_W0 : BLK_W;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic             DONE_ON_ENTRY = (BLANK_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DWELL, BLANK} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [COST_W-1:0] cost_r, cost_g, cost_b, max_cost;
  logic [COST_W-1:0] pix_max;

  always_comb begin
    pix_max = pixel_red_cost;
    if (pixel_green_cost > pix_max) pix_max = pixel_green_cost;
    if (pixel_blue_cost > pix_max)  pix_max = pixel_blue_cost;
  end

  assign cnt_inc   = cnt + 1'b1;
  assign pix_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);

  // Lasers are computed for the *next* cycle so the registered enables line up with DWELL.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cost_r      <= '0;
      cost_g      <= '0;
      cost_b      <= '0;
      max_cost    <= '0;
      galvo_x     <= '0;
      galvo_y     <= '0;
      laser_red   <= 1'b0;
      laser_green <= 1'b0;
      laser_blue  <= 1'b0;
      pixel_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pix_valid) begin
            cost_r   <= pixel_red_cost;
            cost_g   <= pixel_green_cost;
            cost_b   <= pixel_blue_cost;
            max_cost <= pix_max;
            galvo_x  <= pix_x;
            galvo_y  <= pix_y;
            cnt      <= '0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (max_cost != '0) begin
              state       <= DWELL;
              laser_red   <= (cost_r != '0);
              laser_green <= (cost_g != '0);
              laser_blue  <= (cost_b != '0);
            end else begin
              state      <= BLANK;
              pixel_done <= DONE_ON_ENTRY;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        DWELL: begin
          if (cnt_inc < CNT_W'(max_cost)) begin
            cnt         <= cnt_inc;
            laser_red   <= (cnt_inc < CNT_W'(cost_r));
            laser_green <= (cnt_inc < CNT_W'(cost_g));
            laser_blue  <= (cnt_inc < CNT_W'(cost_b));
          end else begin
            cnt         <= '0;
            laser_red   <= 1'b0;
            laser_green <= 1'b0;
            laser_blue  <= 1'b0;
            pixel_done  <= DONE_ON_ENTRY;
            state       <= BLANK;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt        <= '0;
            pixel_done <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt        <= cnt_inc;
            pixel_done <= (cnt_inc == BLANK_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LASER_DWELL_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_pixels    <= '0;
      stat_on_cycles <= '0;
    end else begin
      if (pixel_done) stat_pixels <= stat_pixels + 1'b1;
      if (laser_red || laser_green || laser_blue) stat_on_cycles <= stat_on_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_laser_dwell_sequencer.sv
// Scoreboard bench for laser_dwell_sequencer: driver pushes per-pixel expectations,
// a negedge monitor checks galvo, per-colour dwell windows, done timing and ready return.
module tb_laser_dwell_sequencer;
  localparam int COST_W = 9;
  localparam int POS_W  = 10;
  localparam int S      = 4;
  localparam int B      = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              pix_valid = 1'b0;
  logic              pix_ready;
  logic [POS_W-1:0]  pix_x = '0, pix_y = '0;
  logic [COST_W-1:0] pr = '0, pg = '0, pb = '0;
  logic [POS_W-1:0]  galvo_x, galvo_y;
  logic              laser_red, laser_green, laser_blue, busy, pixel_done;
`ifdef LASER_DWELL_STATS_EN
  logic [31:0]       stat_pixels, stat_on_cycles;
  int                done_count = 0;
  longint            on_exp = 0;
`endif

  laser_dwell_sequencer #(
    .COST_W(COST_W), .POS_W(POS_W), .SETTLE_CYCLES(S), .BLANK_CYCLES(B)
  ) dut (
    .clock(clock), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y),
    .pixel_red_cost(pr), .pixel_green_cost(pg), .pixel_blue_cost(pb),
    .galvo_x(galvo_x), .galvo_y(galvo_y),
    .laser_red(laser_red), .laser_green(laser_green), .laser_blue(laser_blue),
    .busy(busy), .pixel_done(pixel_done)
`ifdef LASER_DWELL_STATS_EN
    , .stat_pixels(stat_pixels), .stat_on_cycles(stat_on_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int x; int y; int r; int g; int b; int m; int e0;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cnt[3], acc_first[3], acc_last[3];
  bit   expect_ready = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input longint got, input longint expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic clear_acc();
    for (int c = 0; c < 3; c++) begin
      acc_cnt[c] = 0; acc_first[c] = -1; acc_last[c] = -1;
    end
  endtask

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Monitor
  always @(negedge clock) begin : monitor
    logic [2:0] l;
    exp_t       e;
    int         cst[3];
    if (!reset) begin
      l = {laser_blue, laser_green, laser_red};
      if (expect_ready) begin
        check("ready_after_done", pix_ready, 1);
        expect_ready = 0;
      end
      if (q.size() == 0) begin
        if (l != 3'b000) check("spurious_laser", l, 0);
        if (pixel_done)  check("spurious_done", pixel_done, 0);
      end else begin
        if (busy) begin
          check("galvo_x_hold", galvo_x, q[0].x);
          check("galvo_y_hold", galvo_y, q[0].y);
        end
        for (int c = 0; c < 3; c++) begin
          if (l[c]) begin
            acc_cnt[c]++;
            if (acc_first[c] < 0) acc_first[c] = cyc;
            acc_last[c] = cyc;
          end
        end
        if (pixel_done) begin
          e = q.pop_front();
          cst[0] = e.r; cst[1] = e.g; cst[2] = e.b;
          check("done_cycle", cyc, e.e0 + S + e.m + B - 1);
          check("ready_low_at_done", pix_ready, 0);
          check("done_lasers_off", l, 0);
          for (int c = 0; c < 3; c++) begin
            check($sformatf("on_cycles_c%0d", c), acc_cnt[c], cst[c]);
            if (cst[c] > 0) begin
              check($sformatf("first_on_c%0d", c), acc_first[c], e.e0 + S);
              check($sformatf("contiguous_c%0d", c), acc_last[c], e.e0 + S + cst[c] - 1);
            end
          end
`ifdef LASER_DWELL_STATS_EN
          done_count++;
          on_exp += e.m;
`endif
          expect_ready = 1;
          clear_acc();
        end
      end
    end
  end

  // Driver: present a pixel, showing junk data while not ready; call at a negedge.
  task automatic send(input int x, input int y, input int r, input int g, input int b,
                      input bit keep, output int e0);
    int unsigned w;
    w = 0;
    pix_valid = 1'b1;
    while (!pix_ready && w < 3000) begin
      pix_x = POS_W'($urandom); pix_y = POS_W'($urandom);
      pr = COST_W'($urandom); pg = COST_W'($urandom); pb = COST_W'($urandom);
      @(negedge clock);
      w++;
    end
    if (!pix_ready) begin
      check("ready_timeout", pix_ready, 1);
      e0 = -1;
      pix_valid = 1'b0;
      return;
    end
    pix_x = POS_W'(x); pix_y = POS_W'(y);
    pr = COST_W'(r); pg = COST_W'(g); pb = COST_W'(b);
    e0 = cyc + 1;
    q.push_back('{x, y, r, g, b, max3(r, g, b), e0});
    @(negedge clock);
    if (!keep) pix_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned w;
    w = 0;
    while (!(q.size() == 0 && pix_ready && !expect_ready) && w < 3000) begin
      @(negedge clock);
      w++;
    end
    if (w >= 3000) check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int e0;
    int unsigned w;
    clear_acc();

    // Reset with valid asserted
    pix_valid = 1'b1; pix_x = 10'd7; pix_y = 10'd9; pr = 9'd4; pg = 9'd4; pb = 9'd4;
    repeat (3) @(negedge clock);
    check("rst_ready", pix_ready, 0);
    check("rst_galvo_x", galvo_x, 0);
    check("rst_galvo_y", galvo_y, 0);
    check("rst_lasers", {laser_red, laser_green, laser_blue}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", pixel_done, 0);
    reset = 1'b0;
    #1 check("ready_after_release", pix_ready, 1);
    pix_valid = 1'b0;
    @(negedge clock);

    // Directed pixels
    send(100, 50, 3, 1, 0, 1'b0, e0);
    wait_idle();
    send(12, 34, 0, 0, 0, 1'b0, e0);
    wait_idle();
    send(1023, 0, 511, 511, 511, 1'b0, e0);
    wait_idle();
    send(200, 300, 2, 6, 4, 1'b1, e0);
    send(400, 500, 1, 0, 7, 1'b0, e0);
    wait_idle();

    // Reset during DWELL k=2 of an R=5 pixel
    send(77, 88, 5, 2, 0, 1'b0, e0);
    w = 0;
    do begin
      @(posedge clock);
      #1;
      w++;
    end while (cyc < e0 + S + 2 && w < 100);
    check("pre_reset_red", laser_red, 1);
    reset = 1'b1;
    #1;
    check("reset_red_drop", laser_red, 0);
    check("reset_lasers", {laser_green, laser_blue}, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", pix_ready, 0);
    check("reset_galvo", {galvo_x, galvo_y}, 0);
`ifdef LASER_DWELL_STATS_EN
    check("reset_stat_pixels", stat_pixels, 0);
    check("reset_stat_on", stat_on_cycles, 0);
    done_count = 0;
    on_exp = 0;
`endif
    q.delete();
    clear_acc();
    expect_ready = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    send(100, 50, 3, 1, 0, 1'b0, e0);
    wait_idle();

    // Randomized pixels
    for (int i = 0; i < 40; i++) begin
      int r, g, b;
      bit keep;
      if ($urandom_range(0, 7) == 0) begin
        r = 511; g = $urandom_range(0, 511); b = $urandom_range(0, 3);
      end else begin
        r = $urandom_range(0, 12); g = $urandom_range(0, 12); b = $urandom_range(0, 12);
      end
      keep = $urandom_range(0, 1);
      send($urandom_range(0, 1023), $urandom_range(0, 1023), r, g, b, keep, e0);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    pix_valid = 1'b0;
    wait_idle();

`ifdef LASER_DWELL_STATS_EN
    check("stat_pixels", stat_pixels, done_count);
    check("stat_on_cycles", stat_on_cycles, on_exp);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
